// File: rtl/reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter
//
// Shares the single write port of a register bank among NREQ requesters
// (ALU result, memory load, PC update, ...). Round-robin arbitration with an
// optional lock that lets one requester issue back-to-back beats, up to
// MAX_LOCK of them, before it is forced to let the others in.
//
// Handshake: a requester raises req[i] with req_addr/req_data slice i stable
// and holds them until it sees ack[i]; the cycle ack[i] is high is the cycle
// the beat is consumed (reg_we/reg_din present, bank writes at the edge that
// ends it). The requester may present its next beat in the following cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high
//   req        request per requester
//   req_lock   ask for back-to-back beats while asserted with req
//   req_addr   target register per requester, slice i = [i*AW +: AW]
//   req_data   write data per requester, slice i = [i*WIDTH +: WIDTH]
//   ack        one-hot pulse, beat consumed (coincident with reg_we)
//   reg_we     one-hot write enable to the register bank
//   reg_din    write data to the register bank
//   err        pulses with ack when the granted address is >= NREGS
//   busy       high while a beat is being presented (GRANT or BURST)
//   dbg_state  current FSM state (0 IDLE, 1 GRANT, 2 BURST)
// ---------------------------------------------------------------------------
module reg_write_arbiter #(
  parameter int WIDTH    = 16,
  parameter int NREQ     = 3,
  parameter int NREGS    = 6,
  parameter int AW       = 3,
  parameter int MAX_LOCK = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_lock,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       ack,
  output logic [NREGS-1:0]      reg_we,
  output logic [WIDTH-1:0]      reg_din,
  output logic                  err,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LOCK);

  // The state describes what is on the outputs right now: IDLE = nothing,
  // GRANT = a single beat, BURST = a locked beat from requester 'hold'.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [PW-1:0]    rr_ptr, rr_ptr_d;
  logic [PW-1:0]    hold, hold_d;
  logic [CW-1:0]    lock_cnt, lock_cnt_d;

  logic [NREQ-1:0]  ack_d;
  logic [NREGS-1:0] reg_we_d;
  logic [WIDTH-1:0] reg_din_d;
  logic             err_d;

  logic [NREQ-1:0]  elig;
  logic             found;
  logic [PW-1:0]    win;
  logic             hold_go;
  logic             sel_valid;
  logic [PW-1:0]    sel;
  logic [AW-1:0]    sel_addr;

  function automatic logic [PW-1:0] wrap(input int v);
    return PW'(v % NREQ);
  endfunction

  // A requester acked this cycle still shows req (it drops it next cycle),
  // so it must not be granted again off the same request. In BURST the ack
  // is always the holder's, so this mask also covers the forced release.
  assign elig = req & ~ack;

  // Round-robin search starting at rr_ptr.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && elig[wrap(int'(rr_ptr) + k)]) begin
        found = 1'b1;
        win   = wrap(int'(rr_ptr) + k);
      end
    end
  end

  // Holder keeps the port while it keeps req and lock and has beats left.
  assign hold_go = (state == BURST) && req[hold] && req_lock[hold] &&
                   (lock_cnt < MAX_CNT);

  always_comb begin
    state_d    = state;
    rr_ptr_d   = rr_ptr;
    hold_d     = hold;
    lock_cnt_d = lock_cnt;
    sel_valid  = 1'b0;
    sel        = '0;
    sel_addr   = '0;
    ack_d      = '0;
    reg_we_d   = '0;
    reg_din_d  = '0;
    err_d      = 1'b0;

    if (hold_go) begin
      // Locked beat: pointer stays put so the others keep their place.
      sel_valid  = 1'b1;
      sel        = hold;
      lock_cnt_d = lock_cnt + 1'b1;
      state_d    = BURST;
    end else begin
      if ((state == BURST) && (lock_cnt == MAX_CNT)) begin
        rr_ptr_d = wrap(int'(hold) + 1);
      end
      if (found) begin
        sel_valid  = 1'b1;
        sel        = win;
        rr_ptr_d   = wrap(int'(win) + 1);
        hold_d     = win;
        lock_cnt_d = CW'(1);
        state_d    = (req_lock[win] && (MAX_LOCK > 1)) ? BURST : GRANT;
      end else begin
        state_d = IDLE;
      end
    end

    if (sel_valid) begin
      ack_d[sel] = 1'b1;
      reg_din_d  = req_data[int'(sel)*WIDTH +: WIDTH];
      sel_addr   = req_addr[int'(sel)*AW +: AW];
      if (int'(sel_addr) < NREGS) begin
        for (int r = 0; r < NREGS; r++) begin
          reg_we_d[r] = (int'(sel_addr) == r);
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      hold     <= '0;
      lock_cnt <= '0;
      ack      <= '0;
      reg_we   <= '0;
      reg_din  <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_d;
      rr_ptr   <= rr_ptr_d;
      hold     <= hold_d;
      lock_cnt <= lock_cnt_d;
      ack      <= ack_d;
      reg_we   <= reg_we_d;
      reg_din  <= reg_din_d;
      err      <= err_d;
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_write_arbiter
//
// Directed bench for reg_write_arbiter (WIDTH=16, NREQ=3, NREGS=6, AW=3,
// MAX_LOCK=4). Inputs change and outputs are sampled 1ns after the rising
// edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_reg_write_arbiter;

  localparam int WIDTH = 16;
  localparam int NREQ  = 3;
  localparam int NREGS = 6;
  localparam int AW    = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       req_lock;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       ack;
  logic [NREGS-1:0]      reg_we;
  logic [WIDTH-1:0]      reg_din;
  logic                  err;
  logic                  busy;
  logic [1:0]            dbg_state;

  int checks = 0;
  int errors = 0;

  reg_write_arbiter #(
    .WIDTH(WIDTH), .NREQ(NREQ), .NREGS(NREGS), .AW(AW), .MAX_LOCK(4)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_lock(req_lock),
    .req_addr(req_addr), .req_data(req_data), .ack(ack), .reg_we(reg_we),
    .reg_din(reg_din), .err(err), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // checking
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [AW-1:0] a,
                          input logic [WIDTH-1:0] d);
    req_addr[i*AW +: AW]       = a;
    req_data[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic check_beat(input string tag, input logic [2:0] e_ack,
                            input logic [5:0] e_we, input logic [15:0] e_din,
                            input logic e_err);
    check({tag, "_ack"}, 32'(ack), 32'(e_ack));
    check({tag, "_we"},  32'(reg_we), 32'(e_we));
    check({tag, "_din"}, 32'(reg_din), 32'(e_din));
    check({tag, "_err"}, 32'(err), 32'(e_err));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ack"},  32'(ack), 0);
    check({tag, "_we"},   32'(reg_we), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_st"},   32'(dbg_state), 0);
  endtask

  logic [2:0] burst_ack [6];

  initial begin
    reset    = 1'b1;
    req      = '0;
    req_lock = '0;
    req_addr = '0;
    req_data = '0;

    // 1. reset held 100ns, nothing requested
    for (int i = 0; i < 9; i++) begin
      #10;
      check("rst_outs", {ack, reg_we, reg_din, err, busy}, 0);
    end
    #10;
    reset = 1'b0;
    tick();
    tick();
    check_idle("post_rst");
    check("post_rst_din", 32'(reg_din), 0);
    check("post_rst_err", 32'(err), 0);

    // 3. three requesters held: rotate 0,1,2,0
    set_slot(0, 3'd0, 16'd30);
    set_slot(1, 3'd1, 16'd31);
    set_slot(2, 3'd3, 16'd32);
    req = 3'b111;
    tick();
    check_beat("rr0", 3'b001, 6'b000001, 16'd30, 1'b0);
    check("rr0_busy", 32'(busy), 1);
    tick();
    check_beat("rr1", 3'b010, 6'b000010, 16'd31, 1'b0);
    tick();
    check_beat("rr2", 3'b100, 6'b001000, 16'd32, 1'b0);
    tick();
    check_beat("rr3", 3'b001, 6'b000001, 16'd30, 1'b0);
    req = 3'b000;
    tick();
    check_idle("rr_end");

    // 4. rr_ptr now 1; req 011 with lock on 1: four locked beats, then 0, then 1
    set_slot(0, 3'd4, 16'd40);
    set_slot(1, 3'd5, 16'd41);
    req      = 3'b011;
    req_lock = 3'b010;
    burst_ack = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b001, 3'b010};
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("lock%0d_ack", i), 32'(ack), 32'(burst_ack[i]));
      if (burst_ack[i] == 3'b010) begin
        check($sformatf("lock%0d_din", i), 32'(reg_din), 41);
        check($sformatf("lock%0d_we", i), 32'(reg_we), 32'(6'b100000));
        check($sformatf("lock%0d_st", i), 32'(dbg_state), 2);
      end else begin
        check($sformatf("lock%0d_din", i), 32'(reg_din), 40);
        check($sformatf("lock%0d_we", i), 32'(reg_we), 32'(6'b010000));
        check($sformatf("lock%0d_st", i), 32'(dbg_state), 1);
      end
    end
    req      = 3'b000;
    req_lock = 3'b000;
    tick();
    check_idle("lock_end");

    // 2. single beat from requester 0
    set_slot(0, 3'd2, 16'd10);
    req = 3'b001;
    tick();
    check_beat("one", 3'b001, 6'b000100, 16'd10, 1'b0);
    check("one_busy", 32'(busy), 1);
    req = 3'b000;
    tick();
    check_idle("one_end");
    tick();
    check_idle("one_end2");

    // 5. illegal addresses 7 and 6 (== NREGS), then legal 5 at the boundary
    set_slot(2, 3'd7, 16'd77);
    req = 3'b100;
    tick();
    check_beat("bad7", 3'b100, 6'b000000, 16'd77, 1'b1);
    req = 3'b000;
    tick();
    check("bad7_clr_err", 32'(err), 0);
    check_idle("bad7_end");
    set_slot(2, 3'd6, 16'd66);
    req = 3'b100;
    tick();
    check_beat("bad6", 3'b100, 6'b000000, 16'd66, 1'b1);
    set_slot(2, 3'd5, 16'd55);
    tick();
    check_idle("bad6_gap");
    tick();
    check_beat("ok5", 3'b100, 6'b100000, 16'd55, 1'b0);
    req = 3'b000;
    tick();
    check_idle("ok5_end");

    // 6. reset in the middle of a burst
    set_slot(1, 3'd1, 16'h0055);
    req      = 3'b010;
    req_lock = 3'b010;
    tick();
    check_beat("pre_rst0", 3'b010, 6'b000010, 16'h0055, 1'b0);
    tick();
    check("pre_rst1_st", 32'(dbg_state), 2);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_ack", 32'(ack), 0);
    check("mid_rst_we", 32'(reg_we), 0);
    check("mid_rst_busy", 32'(busy), 0);
    req      = 3'b000;
    req_lock = 3'b000;
    #14;
    reset = 1'b0;
    tick();
    tick();
    check_idle("after_rst");
    set_slot(0, 3'd0, 16'h0123);
    set_slot(2, 3'd2, 16'h0321);
    req = 3'b111;
    tick();
    check_beat("after_rst_first", 3'b001, 6'b000001, 16'h0123, 1'b0);
    req = 3'b000;
    tick();
    check_idle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
